// File: rtl/dram_arb.sv
// Two-master arbiter in front of a single-port memory. Round-robin arbitration with
// bounded lock bursts, a registered memory command stage and a read return pipeline.
module dram_arb #(
  parameter int ADDR      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             m0_req_i,
  input  logic             m0_we_i,
  input  logic             m0_lock_i,
  input  logic [ADDR-1:0]  m0_addr_i,
  input  logic [WIDTH-1:0] m0_wr_data_i,
  input  logic             m1_req_i,
  input  logic             m1_we_i,
  input  logic             m1_lock_i,
  input  logic [ADDR-1:0]  m1_addr_i,
  input  logic [WIDTH-1:0] m1_wr_data_i,
  output logic             m0_gnt_o,
  output logic             m1_gnt_o,
  output logic             m0_rd_valid_o,
  output logic             m1_rd_valid_o,
  output logic [WIDTH-1:0] m0_rd_data_o,
  output logic [WIDTH-1:0] m1_rd_data_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic             mem_wr_en_o,
  output logic [WIDTH-1:0] mem_wr_data_o,
  output logic             mem_rd_en_o,
  input  logic [WIDTH-1:0] mem_rd_data_i
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       burst_q, burst_d;
  logic [ADDR-1:0]  mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic             mem_wr_en_q, mem_wr_en_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic             mem_src_q, mem_src_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_src_q, rd_src_d;

  logic             gnt0, gnt1, any_gnt, win, win_we, win_lock, owner;
  logic [ADDR-1:0]  win_addr;
  logic [WIDTH-1:0] win_data;
  logic [3:0]       burst_inc;

  // ptr_q=1 gives m1 priority; the last winner (and thus any lock owner) is ~ptr_q.
  assign owner = ~ptr_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn_i) begin
      if (state_q == LOCKED && !owner && m0_req_i)      gnt0 = 1'b1;
      else if (state_q == LOCKED && owner && m1_req_i)  gnt1 = 1'b1;
      else if (m0_req_i && (!m1_req_i || !ptr_q))       gnt0 = 1'b1;
      else if (m1_req_i)                                gnt1 = 1'b1;
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign win      = gnt1;
  assign win_we   = win ? m1_we_i      : m0_we_i;
  assign win_lock = win ? m1_lock_i    : m0_lock_i;
  assign win_addr = win ? m1_addr_i    : m0_addr_i;
  assign win_data = win ? m1_wr_data_i : m0_wr_data_i;

  // A locked beat by the current owner extends the burst; any other locked beat starts one.
  assign burst_inc = (state_q == LOCKED && win == owner) ? burst_q + 4'd1 : 4'd1;

  always_comb begin
    state_d       = IDLE;
    ptr_d         = ptr_q;
    burst_d       = 4'd0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_src_d     = mem_src_q;
    rd_valid_d    = mem_rd_en_q;
    rd_src_d      = mem_src_q;
    if (any_gnt) begin
      ptr_d         = ~win;
      mem_addr_d    = win_addr;
      mem_wr_data_d = win_data;
      mem_wr_en_d   = win_we;
      mem_rd_en_d   = ~win_we;
      mem_src_d     = win;
      if (win_lock && burst_inc != 4'(MAX_BURST)) begin
        state_d = LOCKED;
        burst_d = burst_inc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      burst_q       <= 4'd0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_src_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_src_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      burst_q       <= burst_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_src_q     <= mem_src_d;
      rd_valid_q    <= rd_valid_d;
      rd_src_q      <= rd_src_d;
    end
  end

  assign m0_gnt_o      = gnt0;
  assign m1_gnt_o      = gnt1;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_wr_data_o = mem_wr_data_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign m0_rd_valid_o = rd_valid_q & ~rd_src_q;
  assign m1_rd_valid_o = rd_valid_q & rd_src_q;
  assign m0_rd_data_o  = m0_rd_valid_o ? mem_rd_data_i : '0;
  assign m1_rd_data_o  = m1_rd_valid_o ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_dram_arb.sv
// Testbench for dram_arb: directed arbitration/lock/reset scenarios plus a random run,
// with a memory model and a read scoreboard checking every cycle.
module tb_dram_arb;
  localparam int ADDR  = 4;
  localparam int WIDTH = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 1 << ADDR;

  logic             clk_i, rstn_i;
  logic             m0_req_i, m0_we_i, m0_lock_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [ADDR-1:0]  m0_addr_i, m1_addr_i, mem_addr_o;
  logic [WIDTH-1:0] m0_wr_data_i, m1_wr_data_i, m0_rd_data_o, m1_rd_data_o;
  logic [WIDTH-1:0] mem_wr_data_o, mem_rd_data_i;
  logic             m0_gnt_o, m1_gnt_o, m0_rd_valid_o, m1_rd_valid_o;
  logic             mem_wr_en_o, mem_rd_en_o;

  dram_arb #(.ADDR(ADDR), .WIDTH(WIDTH), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
    .m0_addr_i(m0_addr_i), .m0_wr_data_i(m0_wr_data_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
    .m1_addr_i(m1_addr_i), .m1_wr_data_i(m1_wr_data_i),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_rd_valid_o(m0_rd_valid_o), .m1_rd_valid_o(m1_rd_valid_o),
    .m0_rd_data_o(m0_rd_data_o), .m1_rd_data_o(m1_rd_data_o),
    .mem_addr_o(mem_addr_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_rd_en_o(mem_rd_en_o),
    .mem_rd_data_i(mem_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks, n_errors;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Memory: read data appears the cycle after the read strobe; cleared while in reset.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem_rd_data_i <= '0;
    end else begin
      if (mem_wr_en_o) mem[mem_addr_o] <= mem_wr_data_o;
      if (mem_rd_en_o) mem_rd_data_i <= mem[mem_addr_o];
    end
  end

  typedef struct {
    logic             src;
    logic [WIDTH-1:0] data;
    int               due;
  } rd_exp_t;

  rd_exp_t          rd_q[$];
  rd_exp_t          e_pop, e_push;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic             exp_wr_en, exp_rd_en;
  logic [ADDR-1:0]  exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic             s_we;
  logic [ADDR-1:0]  s_addr;
  logic [WIDTH-1:0] s_data;
  int               cyc, wait0, wait1;

  // Scoreboard: every granted beat predicts the next memory command and, for reads, the return.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      rd_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_wr_en = 1'b0; exp_rd_en = 1'b0; exp_addr = '0; exp_data = '0;
      wait0 = 0; wait1 = 0; cyc = 0;
    end else begin
      cyc++;
      checkOutput("mem_wr_en", mem_wr_en_o, exp_wr_en);
      checkOutput("mem_rd_en", mem_rd_en_o, exp_rd_en);
      checkOutput("mem_addr", mem_addr_o, exp_addr);
      checkOutput("mem_wr_data", mem_wr_data_o, exp_data);
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        e_pop = rd_q.pop_front();
        checkOutput("m0_rd_valid", m0_rd_valid_o, !e_pop.src);
        checkOutput("m1_rd_valid", m1_rd_valid_o, e_pop.src);
        checkOutput("rd_data", e_pop.src ? m1_rd_data_o : m0_rd_data_o, e_pop.data);
      end else begin
        checkOutput("m0_rd_valid_idle", m0_rd_valid_o, 0);
        checkOutput("m1_rd_valid_idle", m1_rd_valid_o, 0);
      end
      checkOutput("double_gnt", m0_gnt_o & m1_gnt_o, 0);
      checkOutput("gnt_without_req", (m0_gnt_o & !m0_req_i) | (m1_gnt_o & !m1_req_i), 0);
      exp_wr_en = 1'b0;
      exp_rd_en = 1'b0;
      if (m0_gnt_o || m1_gnt_o) begin
        s_we   = m1_gnt_o ? m1_we_i      : m0_we_i;
        s_addr = m1_gnt_o ? m1_addr_i    : m0_addr_i;
        s_data = m1_gnt_o ? m1_wr_data_i : m0_wr_data_i;
        exp_wr_en = s_we;
        exp_rd_en = !s_we;
        exp_addr  = s_addr;
        exp_data  = s_data;
        if (s_we) ref_mem[s_addr] = s_data;
        else begin
          e_push.src  = m1_gnt_o;
          e_push.data = ref_mem[s_addr];
          e_push.due  = cyc + 2;
          rd_q.push_back(e_push);
        end
      end
      wait0 = (m0_req_i && !m0_gnt_o) ? wait0 + 1 : 0;
      wait1 = (m1_req_i && !m1_gnt_o) ? wait1 + 1 : 0;
      checkOutput("m0_wait_bound", wait0 > MB + 1, 0);
      checkOutput("m1_wait_bound", wait1 > MB + 1, 0);
    end
  end

  task automatic applyStimulus(
    input logic r0, input logic w0, input logic l0, input logic [ADDR-1:0] a0, input logic [WIDTH-1:0] d0,
    input logic r1, input logic w1, input logic l1, input logic [ADDR-1:0] a1, input logic [WIDTH-1:0] d1);
    m0_req_i = r0; m0_we_i = w0; m0_lock_i = l0; m0_addr_i = a0; m0_wr_data_i = d0;
    m1_req_i = r1; m1_we_i = w1; m1_lock_i = l1; m1_addr_i = a1; m1_wr_data_i = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn_i = 1'b0;
    repeat (2) next_cycle();
    rstn_i = 1'b1;
  endtask

  task automatic check_gnt(input string tag, input logic e0, input logic e1);
    @(negedge clk_i);
    checkOutput({tag, "_m0_gnt"}, m0_gnt_o, e0);
    checkOutput({tag, "_m1_gnt"}, m1_gnt_o, e1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic g0, g1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_i    = 1'b0;
    rstn_i   = 1'b0;
    applyStimulus(1, 1, 0, 4'd2, 8'h11, 1, 1, 0, 4'd3, 8'h22);
    #2;
    checkOutput("rst_m0_gnt", m0_gnt_o, 0);
    checkOutput("rst_m1_gnt", m1_gnt_o, 0);
    checkOutput("rst_mem_en", {mem_wr_en_o, mem_rd_en_o}, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_data", mem_wr_data_o, 0);
    checkOutput("rst_rd_valid", {m0_rd_valid_o, m1_rd_valid_o}, 0);
    do_reset();

    // Write then read back through m0 alone.
    applyStimulus(1, 1, 0, 4'd3, 8'h5A, 0, 0, 0, 0, 0);
    check_gnt("t1_wr", 1, 0);
    next_cycle();
    applyStimulus(1, 0, 0, 4'd3, 8'h00, 0, 0, 0, 0, 0);
    check_gnt("t1_rd", 1, 0);
    checkOutput("t1_mem_wr_en", mem_wr_en_o, 1);
    checkOutput("t1_mem_addr", mem_addr_o, 3);
    checkOutput("t1_mem_wr_data", mem_wr_data_o, 8'h5A);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    checkOutput("t1_mem_rd_en", mem_rd_en_o, 1);
    next_cycle();
    @(negedge clk_i);
    checkOutput("t1_m0_rd_valid", m0_rd_valid_o, 1);
    checkOutput("t1_m0_rd_data", m0_rd_data_o, 8'h5A);
    checkOutput("t1_m1_rd_valid", m1_rd_valid_o, 0);
    next_cycle();

    // Both masters reading continuously alternate starting with m0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 4'd3, 0, 1, 0, 0, 4'd5, 0);
      check_gnt("t2_rr", (i % 2) == 0, (i % 2) == 1);
      next_cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();

    // m0 locked burst is cut after MB beats in favour of m1.
    do_reset();
    for (int i = 0; i <= MB; i++) begin
      applyStimulus(1, 1, 1, 4'(4 + i), 8'(8'h30 + i), 1, 1, 0, 4'd9, 8'h99);
      check_gnt("t3_burst", i < MB, i == MB);
      next_cycle();
    end

    // m1 locked burst ends early when its second beat drops lock.
    do_reset();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 4'd6, 8'h11);
    check_gnt("t4_beat1", 0, 1);
    next_cycle();
    applyStimulus(1, 0, 0, 4'd6, 0, 1, 1, 0, 4'd7, 8'h22);
    check_gnt("t4_beat2", 0, 1);
    next_cycle();
    applyStimulus(1, 0, 0, 4'd6, 0, 0, 0, 0, 0, 0);
    check_gnt("t4_after", 1, 0);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();

    // Reset one cycle after a read grant discards the read.
    do_reset();
    applyStimulus(1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0);
    check_gnt("t5_rd", 1, 0);
    next_cycle();
    applyStimulus(1, 1, 0, 4'd8, 8'h33, 1, 1, 0, 4'd9, 8'h44);
    rstn_i = 1'b0;
    #1;
    checkOutput("t5_gnt", {m0_gnt_o, m1_gnt_o}, 0);
    checkOutput("t5_mem_en", {mem_wr_en_o, mem_rd_en_o}, 0);
    checkOutput("t5_mem_addr", mem_addr_o, 0);
    checkOutput("t5_mem_data", mem_wr_data_o, 0);
    checkOutput("t5_rd_valid", {m0_rd_valid_o, m1_rd_valid_o}, 0);
    checkOutput("t5_rd_data", {m0_rd_data_o, m1_rd_data_o}, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    check_gnt("t5_first", 1, 0);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 4'd9, 8'h44);
    check_gnt("t5_second", 0, 1);
    next_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("t5_no_stale_valid", {m0_rd_valid_o, m1_rd_valid_o}, 0);
      next_cycle();
    end

    // Random traffic; each master holds its request until granted.
    do_reset();
    g0 = 1'b1;
    g1 = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (!m0_req_i || g0) begin
        m0_req_i     = $urandom_range(0, 9) < 7;
        m0_we_i      = 1'($urandom_range(0, 1));
        m0_lock_i    = 1'($urandom_range(0, 1));
        m0_addr_i    = 4'($urandom_range(0, DEPTH - 1));
        m0_wr_data_i = 8'($urandom_range(0, 255));
      end
      if (!m1_req_i || g1) begin
        m1_req_i     = $urandom_range(0, 9) < 7;
        m1_we_i      = 1'($urandom_range(0, 1));
        m1_lock_i    = 1'($urandom_range(0, 1));
        m1_addr_i    = 4'($urandom_range(0, DEPTH - 1));
        m1_wr_data_i = 8'($urandom_range(0, 255));
      end
      @(negedge clk_i);
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      next_cycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) next_cycle();
    checkOutput("rd_queue_drained", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
